// File: rtl/music_pkg.sv
// Shared widths and constants for the song-playback blocks.
package music_pkg;

    localparam int NOTE_W             = 6;
    localparam int DUR_W              = 6;
    localparam int DEFAULT_NUM_VOICES = 4;

    localparam logic [NOTE_W-1:0] REST_NOTE = '0;

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_REST,
        ACT_LOAD,
        ACT_DROP
    } note_action_e;

endpackage

// File: rtl/voice_picker.sv
// Round-robin free-voice search: first idle voice at or after 'start', wrapping.
module voice_picker
    import music_pkg::*;
#(
    parameter int NUM_VOICES = DEFAULT_NUM_VOICES,
    parameter int IDX_W      = $clog2(NUM_VOICES)
) (
    input  logic [NUM_VOICES-1:0] busy,
    input  logic [IDX_W-1:0]      start,
    output logic                  found,
    output logic [IDX_W-1:0]      index
);

    int               pos;
    logic [IDX_W-1:0] pos_idx;

    // Walk from the farthest offset back to the nearest so the nearest free voice wins.
    always_comb begin
        found   = 1'b0;
        index   = '0;
        pos     = 0;
        pos_idx = '0;
        for (int k = NUM_VOICES - 1; k >= 0; k--) begin
            pos     = (int'(start) + k) % NUM_VOICES;
            pos_idx = IDX_W'(pos);
            if (!busy[pos_idx]) begin
                found = 1'b1;
                index = pos_idx;
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Assigns incoming notes to free note-player voices in round-robin order.
// Define VOICE_STEAL_EN to reload the oldest voice when every voice is busy.
module voice_allocator
    import music_pkg::*;
#(
    parameter int NUM_VOICES = DEFAULT_NUM_VOICES,
    parameter int SEQ_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play,
    input  logic                  new_note,
    input  logic [NOTE_W-1:0]     note,
    input  logic [DUR_W-1:0]      duration,
    input  logic [NUM_VOICES-1:0] voice_done,
    output logic [NUM_VOICES-1:0] load_voice,
    output logic [NOTE_W-1:0]     voice_note,
    output logic [DUR_W-1:0]      voice_duration,
    output logic [NUM_VOICES-1:0] voice_busy,
    output logic                  note_accepted,
    output logic                  note_dropped
);

    localparam int               IDX_W    = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    logic [SEQ_W-1:0]      seq;
    logic [SEQ_W-1:0]      stamp [NUM_VOICES];
    logic [IDX_W-1:0]      last_alloc;

    logic [NUM_VOICES-1:0] avail_busy;
    logic [IDX_W-1:0]      start_idx;
    logic                  free_found;
    logic [IDX_W-1:0]      free_idx;
    logic [IDX_W-1:0]      oldest_idx;
    logic [SEQ_W-1:0]      oldest_age;
    logic [SEQ_W-1:0]      age;
    logic [IDX_W-1:0]      target_idx;
    logic [NUM_VOICES-1:0] target_onehot;
    note_action_e          action;

    // A voice finishing this cycle is already free for a note arriving this cycle.
    assign avail_busy = voice_busy & ~voice_done;
    assign start_idx  = (last_alloc == LAST_IDX) ? '0 : last_alloc + 1'b1;

    voice_picker #(
        .NUM_VOICES (NUM_VOICES),
        .IDX_W      (IDX_W)
    ) u_picker (
        .busy  (avail_busy),
        .start (start_idx),
        .found (free_found),
        .index (free_idx)
    );

    // Age is the modular distance back to the stamp; strict '>' keeps ties on the lowest index.
    always_comb begin
        oldest_idx = '0;
        oldest_age = '0;
        age        = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            age = seq - stamp[i];
            if (age > oldest_age) begin
                oldest_age = age;
                oldest_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        action     = ACT_NONE;
        target_idx = free_idx;
        if (new_note) begin
            if (!play) begin
                action = ACT_DROP;
            end else if (note == REST_NOTE) begin
                action = ACT_REST;
            end else if (free_found) begin
                action = ACT_LOAD;
            end else begin
`ifdef VOICE_STEAL_EN
                action     = ACT_LOAD;
                target_idx = oldest_idx;
`else
                action     = ACT_DROP;
`endif
            end
        end
    end

`ifndef VOICE_STEAL_EN
    logic unused_oldest;
    assign unused_oldest = ^oldest_idx;
`endif

    assign target_onehot = {{(NUM_VOICES-1){1'b0}}, 1'b1} << target_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_voice     <= '0;
            voice_note     <= '0;
            voice_duration <= '0;
            voice_busy     <= '0;
            note_accepted  <= 1'b0;
            note_dropped   <= 1'b0;
            seq            <= '0;
            last_alloc     <= LAST_IDX;
            for (int i = 0; i < NUM_VOICES; i++) begin
                stamp[i] <= '0;
            end
        end else begin
            load_voice    <= '0;
            note_accepted <= (action == ACT_REST) || (action == ACT_LOAD);
            note_dropped  <= (action == ACT_DROP);
            voice_busy    <= avail_busy;
            if (action == ACT_LOAD) begin
                load_voice        <= target_onehot;
                voice_busy        <= avail_busy | target_onehot;
                voice_note        <= note;
                voice_duration    <= duration;
                stamp[target_idx] <= seq;
                seq               <= seq + 1'b1;
                last_alloc        <= target_idx;
            end
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Table-driven scoreboard bench for voice_allocator (4 voices), plus reset corner sequences.
module tb_voice_allocator;
    import music_pkg::*;

    localparam int NV = 4;

    typedef struct {
        logic          play;
        logic          nn;
        logic [5:0]    note;
        logic [5:0]    dur;
        logic [NV-1:0] done;
        logic [NV-1:0] exp_load;
        logic [5:0]    exp_note;
        logic [5:0]    exp_dur;
        logic          exp_acc;
        logic          exp_drop;
        logic [NV-1:0] exp_busy;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          play = 1'b0;
    logic          new_note = 1'b0;
    logic [5:0]    note = '0;
    logic [5:0]    duration = '0;
    logic [NV-1:0] voice_done = '0;
    logic [NV-1:0] load_voice;
    logic [5:0]    voice_note;
    logic [5:0]    voice_duration;
    logic [NV-1:0] voice_busy;
    logic          note_accepted;
    logic          note_dropped;

    int   checks = 0;
    int   passed = 0;
    vec_t vecs[$];
    vec_t sb[$];

    voice_allocator #(.NUM_VOICES(NV), .SEQ_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .play           (play),
        .new_note       (new_note),
        .note           (note),
        .duration       (duration),
        .voice_done     (voice_done),
        .load_voice     (load_voice),
        .voice_note     (voice_note),
        .voice_duration (voice_duration),
        .voice_busy     (voice_busy),
        .note_accepted  (note_accepted),
        .note_dropped   (note_dropped)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void add_vec(logic p, logic n, logic [5:0] nt, logic [5:0] dr, logic [NV-1:0] dn,
                                    logic [NV-1:0] el, logic [5:0] en, logic [5:0] ed,
                                    logic ea, logic edr, logic [NV-1:0] eb);
        vec_t v;
        v = '{p, n, nt, dr, dn, el, en, ed, ea, edr, eb};
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        else
            passed++;
    endtask

    // Drive one vector for one cycle, then compare the registered response after the edge.
    task automatic applyStimulus(input vec_t v, input int row);
        vec_t e;
        @(negedge clk);
        play       = v.play;
        new_note   = v.nn;
        note       = v.note;
        duration   = v.dur;
        voice_done = v.done;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checkOutput($sformatf("row%0d load_voice", row), 32'(load_voice), 32'(e.exp_load));
        checkOutput($sformatf("row%0d voice_note", row), 32'(voice_note), 32'(e.exp_note));
        checkOutput($sformatf("row%0d voice_duration", row), 32'(voice_duration), 32'(e.exp_dur));
        checkOutput($sformatf("row%0d note_accepted", row), 32'(note_accepted), 32'(e.exp_acc));
        checkOutput($sformatf("row%0d note_dropped", row), 32'(note_dropped), 32'(e.exp_drop));
        checkOutput($sformatf("row%0d voice_busy", row), 32'(voice_busy), 32'(e.exp_busy));
    endtask

    initial begin
        //       play nn note dur done    load    vnote vdur acc drop busy
        add_vec(1, 1, 10, 3, 4'b0000, 4'b0001, 10, 3,  1, 0, 4'b0001);
        add_vec(1, 0,  0, 0, 4'b0010, 4'b0000, 10, 3,  0, 0, 4'b0001);
        add_vec(1, 1, 12, 4, 4'b0000, 4'b0010, 12, 4,  1, 0, 4'b0011);
        add_vec(1, 0,  0, 0, 4'b0000, 4'b0000, 12, 4,  0, 0, 4'b0011);
        add_vec(1, 1, 14, 5, 4'b0000, 4'b0100, 14, 5,  1, 0, 4'b0111);
        add_vec(1, 0,  0, 0, 4'b0000, 4'b0000, 14, 5,  0, 0, 4'b0111);
        add_vec(1, 1, 16, 6, 4'b0000, 4'b1000, 16, 6,  1, 0, 4'b1111);
        add_vec(1, 0,  0, 0, 4'b0000, 4'b0000, 16, 6,  0, 0, 4'b1111);
        add_vec(1, 0,  0, 0, 4'b0010, 4'b0000, 16, 6,  0, 0, 4'b1101);
        add_vec(1, 1, 20, 7, 4'b0000, 4'b0010, 20, 7,  1, 0, 4'b1111);
`ifdef VOICE_STEAL_EN
        add_vec(1, 1, 30, 8, 4'b0000, 4'b0001, 30, 8,  1, 0, 4'b1111);
`else
        add_vec(1, 1, 30, 8, 4'b0000, 4'b0000, 20, 7,  0, 1, 4'b1111);
`endif
        add_vec(1, 1, 22, 9, 4'b0100, 4'b0100, 22, 9,  1, 0, 4'b1111);
        add_vec(1, 1,  0, 1, 4'b0000, 4'b0000, 22, 9,  1, 0, 4'b1111);
        add_vec(0, 1,  5, 2, 4'b0000, 4'b0000, 22, 9,  0, 1, 4'b1111);
        add_vec(0, 0,  0, 0, 4'b1000, 4'b0000, 22, 9,  0, 0, 4'b0111);
        add_vec(0, 1,  7, 2, 4'b0000, 4'b0000, 22, 9,  0, 1, 4'b0111);
        add_vec(1, 1, 11, 10, 4'b0000, 4'b1000, 11, 10, 1, 0, 4'b1111);

        #12;
        checkOutput("reset load_voice", 32'(load_voice), 32'h0);
        checkOutput("reset voice_busy", 32'(voice_busy), 32'h0);
        checkOutput("reset voice_note", 32'(voice_note), 32'h0);
        checkOutput("reset note_accepted", 32'(note_accepted), 32'h0);
        checkOutput("reset note_dropped", 32'(note_dropped), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) applyStimulus(vecs[i], i);

        @(negedge clk);
        new_note   = 1'b0;
        voice_done = '0;
        play       = 1'b1;

        // Reset with every voice busy clears occupancy without any clock edge.
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("async busy clear", 32'(voice_busy), 32'h0);
        checkOutput("async load clear", 32'(load_voice), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // First note after reset goes to voice 0; a reset in the following cycle kills its strobe.
        @(negedge clk);
        new_note = 1'b1;
        note     = 6'd9;
        duration = 6'd3;
        @(posedge clk);
        #1;
        new_note = 1'b0;
        checkOutput("post-reset load", 32'(load_voice), 32'h1);
        checkOutput("post-reset voice_note", 32'(voice_note), 32'd9);
        checkOutput("post-reset busy", 32'(voice_busy), 32'h1);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("mid-pulse reset load", 32'(load_voice), 32'h0);
        checkOutput("mid-pulse reset busy", 32'(voice_busy), 32'h0);
        checkOutput("mid-pulse reset accepted", 32'(note_accepted), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Reset held across the sampling edge means the note is never loaded.
        @(negedge clk);
        new_note = 1'b1;
        note     = 6'd13;
        duration = 6'd2;
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        new_note = 1'b0;
        checkOutput("held reset load", 32'(load_voice), 32'h0);
        checkOutput("held reset busy", 32'(voice_busy), 32'h0);
        checkOutput("held reset accepted", 32'(note_accepted), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 The block SHALL have parameter NUM_VOICES, default 4, giving the number of note-player voices managed (2..8).
REQ-002 The block SHALL have parameter SEQ_W, default 8, giving the width of the allocation-sequence counter.
REQ-003 clk  input  1  system clock; the block uses this single clock domain.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 play  input  1  high enables allocation; low blocks new allocations.
REQ-006 new_note  input  1  one-cycle pulse from the song reader; note and duration are valid in the same cycle.
REQ-007 note  input  6  note code; 0 is a rest.
REQ-008 duration  input  6  duration in beats.
REQ-009 voice_done  input  NUM_VOICES  per-voice one-cycle pulse when that voice finishes its note.
REQ-010 load_voice  output  NUM_VOICES  one-hot one-cycle load strobe to the selected voice.
REQ-011 voice_note  output  6  note for the voice strobed by load_voice.
REQ-012 voice_duration  output  6  duration for the voice strobed by load_voice.
REQ-013 voice_busy  output  NUM_VOICES  per-voice occupancy flags.
REQ-014 note_accepted  output  1  one-cycle pulse when a new_note is consumed, including rests.
REQ-015 note_dropped  output  1  one-cycle pulse when a new_note is discarded.

Function
REQ-016 All outputs SHALL be registered; load_voice, voice_note, voice_duration and note_accepted SHALL appear exactly 1 cycle after the new_note cycle.
REQ-017 Free-voice search SHALL be round-robin, starting at index (last_alloc+1) mod NUM_VOICES; last_alloc SHALL reset to NUM_VOICES-1 so that the first allocation goes to voice 0.
REQ-018 On allocation, the block SHALL set voice_busy[i], store the current seq value as stamp[i], increment seq modulo 2^SEQ_W, and set last_alloc=i.
REQ-019 voice_done[i] SHALL clear voice_busy[i] at the next edge; voice_done on an idle voice SHALL be ignored.
REQ-020 When voice_done[i] and new_note occur in the same cycle, voice i SHALL count as free for that allocation.
REQ-021 A new_note with note==0 SHALL pulse note_accepted, SHALL NOT pulse load_voice, and SHALL leave all state unchanged.
REQ-022 A new_note while play is low SHALL pulse note_dropped and SHALL change no other state; voice_done SHALL still be honoured while play is low.
REQ-023 The oldest busy voice SHALL be the one with the largest (seq - stamp[i]) mod 2^SEQ_W; ties SHALL go to the lowest index.
REQ-024 voice_note and voice_duration SHALL hold their last value when load_voice is 0.
REQ-025 At most one of note_accepted and note_dropped SHALL pulse per new_note.

Reset
REQ-026 When reset is asserted (low), the block SHALL asynchronously clear load_voice, voice_busy, voice_note, voice_duration, note_accepted, note_dropped, seq and all stamps, and set last_alloc to NUM_VOICES-1.
REQ-027 A reset asserted mid-allocation SHALL suppress the pending load_voice pulse.

Configuration
REQ-028 With macro VOICE_STEAL_EN defined, a non-rest new_note arriving with all voices busy SHALL reload the oldest voice (load_voice pulse, stamp refreshed, note_accepted); voice_busy SHALL remain set.
REQ-029 With VOICE_STEAL_EN undefined, that same new_note SHALL pulse note_dropped and SHALL change no state.

Structure
REQ-030 The shared package music_pkg SHALL hold NOTE_W=6, DUR_W=6, the REST_NOTE=0 constant and the default NUM_VOICES.
REQ-031 The rotate-and-priority free-voice search SHALL be a sub-module, voice_picker, with inputs busy mask and start index and outputs found and index.

Verification
REQ-032 Scenario: after reset, play=1, four notes 10,12,14,16 with 1 cycle between them -> load_voice 0001,0010,0100,1000, each 1 cycle after its new_note, and voice_busy=1111.
REQ-033 Scenario: voice_done=0010, then note 20 -> load_voice=0010, voice_note=20.
REQ-034 Scenario: all voices busy, note 30 -> with VOICE_STEAL_EN, load_voice=0001 (oldest) and note_accepted; without it, note_dropped and no load_voice pulse.
REQ-035 Scenario: all voices busy, voice_done=0100 in the same cycle as new_note 22 -> load_voice=0100 and no drop.
REQ-036 Scenario: note 0 -> note_accepted=1, load_voice=0000, busy unchanged; play=0 with note 5 -> note_dropped=1.
REQ-037 Scenario: reset asserted in the cycle after new_note -> load_voice stays 0 and voice_busy=0000 immediately, without waiting for a clock edge.
